// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-match path: FSM state encodings,
// default time-field limits and the time field width used by the
// comparator bank.
package alarm_pkg;

  // Width of an hour or minute field on the comparator bus.
  localparam int TIME_W = 6;

  // Default wrap limits for the time fields.
  localparam int HOUR_MAX_DEF = 23;
  localparam int MIN_MAX_DEF  = 59;

  // Alarm FSM states; the encoding is exported on state_o for display blinking.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_ARMED    = 3'd3,
    ST_RINGING  = 3'd4
  } state_t;

endpackage

// File: rtl/mod_wrap_cnt.sv
// Time-field register: increments and wraps to zero after MAX.
// A parallel load takes priority over the increment so the parent can
// write a precomputed value into the field.
module mod_wrap_cnt
  import alarm_pkg::*;
#(
  parameter logic [TIME_W-1:0] MAX = 6'd59
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] count
);

  logic [TIME_W-1:0] count_reg;

  // Field register: reset to zero, load wins over increment, wrap at MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (inc) begin
      count_reg <= (count_reg == MAX) ? '0 : count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/alarm_set.sv
// Alarm target holder and ring controller. Holds the alarm hour/minute,
// enables the comparator bank while armed, detects match rises and drives
// the ring output with a tick-based auto-dismiss.
// Optional snooze support is compiled in with ALARM_SNOOZE_EN.
module alarm_set
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_MIN = 5,
  parameter int HOUR_MAX   = HOUR_MAX_DEF,
  parameter int MIN_MAX    = MIN_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_snooze,
  input  logic              match_i,
  output logic [TIME_W-1:0] alarm_hour,
  output logic [TIME_W-1:0] alarm_min,
  output logic              cmp_en,
  output logic              ring,
  output logic [2:0]        state_o
);

  localparam logic [TIME_W-1:0] RING_LIM = TIME_W'(RING_SEC);

  state_t            state_reg;
  logic [TIME_W-1:0] ring_cnt_reg;
  logic              match_q;
  logic              cmp_en_reg;
  logic              ring_reg;

  logic              hour_inc;
  logic              min_inc;
  logic              min_load;
  logic [TIME_W-1:0] min_load_val;
  logic              snooze_go;
  logic              snooze_carry;
  logic [TIME_W-1:0] ring_cnt_plus;

  // btn_mode always wins over btn_inc, so edits only happen without a mode press.
  assign hour_inc = (btn_inc && !btn_mode && state_reg == ST_SET_HOUR) ||
                    (snooze_go && snooze_carry);
  assign min_inc  = btn_inc && !btn_mode && state_reg == ST_SET_MIN;

`ifdef ALARM_SNOOZE_EN
  logic [TIME_W:0] snz_sum;

  // Snooze: add SNOOZE_MIN to the minute with modulo wrap; carry bumps the hour.
  assign snooze_go    = btn_snooze && !btn_mode && state_reg == ST_RINGING;
  assign snz_sum      = {1'b0, alarm_min} + (TIME_W+1)'(SNOOZE_MIN);
  assign snooze_carry = snz_sum > (TIME_W+1)'(MIN_MAX);
  assign min_load     = snooze_go;
  assign min_load_val = snooze_carry ? TIME_W'(snz_sum - (TIME_W+1)'(MIN_MAX + 1))
                                     : snz_sum[TIME_W-1:0];
`else
  logic unused_snooze;

  // Without snooze support the button is accepted but has no effect.
  assign unused_snooze = btn_snooze;
  assign snooze_go     = 1'b0;
  assign snooze_carry  = 1'b0;
  assign min_load      = 1'b0;
  assign min_load_val  = '0;
`endif

  assign ring_cnt_plus = ring_cnt_reg + 1'b1;

  mod_wrap_cnt #(.MAX(TIME_W'(HOUR_MAX))) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (hour_inc),
    .load     (1'b0),
    .load_val ('0),
    .count    (alarm_hour)
  );

  mod_wrap_cnt #(.MAX(TIME_W'(MIN_MAX))) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_inc),
    .load     (min_load),
    .load_val (min_load_val),
    .count    (alarm_min)
  );

  // Mode FSM with registered cmp_en/ring, match edge register and ring timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ring_cnt_reg <= '0;
      match_q      <= 1'b0;
      cmp_en_reg   <= 1'b0;
      ring_reg     <= 1'b0;
    end else begin
      match_q <= match_i;
      case (state_reg)
        ST_IDLE: begin
          if (btn_mode) state_reg <= ST_SET_HOUR;
        end
        ST_SET_HOUR: begin
          if (btn_mode) state_reg <= ST_SET_MIN;
        end
        ST_SET_MIN: begin
          if (btn_mode) begin
            state_reg  <= ST_ARMED;
            cmp_en_reg <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (btn_mode) begin
            state_reg  <= ST_IDLE;
            cmp_en_reg <= 1'b0;
          end else if (match_i && !match_q) begin
            state_reg <= ST_RINGING;
            ring_reg  <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (btn_mode || snooze_go) begin
            state_reg    <= ST_ARMED;
            ring_reg     <= 1'b0;
            ring_cnt_reg <= '0;
          end else if (tick_1hz) begin
            if (ring_cnt_plus == RING_LIM) begin
              state_reg    <= ST_ARMED;
              ring_reg     <= 1'b0;
              ring_cnt_reg <= '0;
            end else begin
              ring_cnt_reg <= ring_cnt_plus;
            end
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          cmp_en_reg <= 1'b0;
          ring_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state_reg;
  assign cmp_en  = cmp_en_reg;
  assign ring    = ring_reg;

endmodule
